// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the program-counter fetch unit.
package pc_fetch_pkg;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    // Next-pc source selection
    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_STEP   = 2'd1,
        SEL_TARGET = 2'd2
    } pc_sel_e;

    // Byte distance between consecutive instructions
    localparam int unsigned PC_STEP = 4;

endpackage : pc_fetch_pkg

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Next-pc selection: hold, sequential step, or pc-relative target.
// All arithmetic wraps modulo 2^PC_WIDTH.
module pc_next_sel
    import pc_fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 10
) (
    input  logic [PC_WIDTH-1:0] pc_i,
    input  logic [PC_WIDTH-1:0] imm_i,
    input  pc_sel_e             sel_i,
    output logic [PC_WIDTH-1:0] target_o,
    output logic [PC_WIDTH-1:0] pc_next_o
);

    logic [PC_WIDTH-1:0] step_pc;

    // Candidate addresses; target is exposed for the alignment check
    always_comb begin
        step_pc  = pc_i + PC_WIDTH'(PC_STEP);
        target_o = pc_i + imm_i;
    end

    // Select the next fetch address
    always_comb begin
        pc_next_o = pc_i;
        case (sel_i)
            SEL_STEP:   pc_next_o = step_pc;
            SEL_TARGET: pc_next_o = target_o;
            default:    pc_next_o = pc_i;
        endcase
    end

endmodule : pc_next_sel

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch sequencer for a single-cycle datapath.
// Optional feature: define PC_FETCH_JUMP_EN to add an unconditional
// jump input that overrides branch, with the same alignment check.
module pc_fetch_unit
    import pc_fetch_pkg::*;
#(
    parameter int unsigned PC_WIDTH = 10,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned PC_LAST  = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch,
    input  logic                zero,
`ifdef PC_FETCH_JUMP_EN
    input  logic                jump,
`endif
    input  logic [31:0]         imm,
    output logic [PC_WIDTH-1:0] pc,
    output logic                fetch_valid,
    output logic                halted,
    output logic                misalign_err
);

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic                misalign_q, misalign_d;
    pc_sel_e             sel;
    logic [PC_WIDTH-1:0] target;
    logic                redirect;

    // Immediate bits above the pc width do not affect the address
    generate
        if (PC_WIDTH < 32) begin : g_imm_unused
            logic unused_imm_hi;
            assign unused_imm_hi = ^imm[31:PC_WIDTH];
        end
    endgenerate

    pc_next_sel #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_next_sel (
        .pc_i      (pc_q),
        .imm_i     (imm[PC_WIDTH-1:0]),
        .sel_i     (sel),
        .target_o  (target),
        .pc_next_o (pc_d)
    );

    // Redirect request: taken branch, or jump when enabled
    always_comb begin
`ifdef PC_FETCH_JUMP_EN
        redirect = jump | (branch & zero);
`else
        redirect = branch & zero;
`endif
    end

    // Next-state and pc source; stall beats redirect, redirect beats halt
    always_comb begin
        state_d    = state_q;
        sel        = SEL_HOLD;
        misalign_d = misalign_q;
        case (state_q)
            IDLE: begin
                state_d = RUN;
            end
            RUN: begin
                if (stall) begin
                    state_d = STALL;
                end else if (redirect) begin
                    if (target[1:0] != 2'b00) begin
                        state_d    = HALT;
                        misalign_d = 1'b1;
                    end else begin
                        sel = SEL_TARGET;
                    end
                end else if (pc_q == PC_WIDTH'(PC_LAST)) begin
                    state_d = HALT;
                end else begin
                    sel = SEL_STEP;
                end
            end
            STALL: begin
                if (!stall) begin
                    state_d = RUN;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pc and sticky error registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= PC_WIDTH'(RESET_PC);
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    // Registered outputs decoded from state
    always_comb begin
        pc           = pc_q;
        fetch_valid  = (state_q == RUN);
        halted       = (state_q == HALT);
        misalign_err = misalign_q;
    end

endmodule : pc_fetch_unit

// File: tb/tb_pc_fetch_unit.sv
// Directed self-checking bench for pc_fetch_unit (default parameters).
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch;
    logic        zero;
`ifdef PC_FETCH_JUMP_EN
    logic        jump;
`endif
    logic [31:0] imm;
    logic [9:0]  pc;
    logic        fetch_valid;
    logic        halted;
    logic        misalign_err;

    int n_cmp;
    int n_bad;

    pc_fetch_unit #(
        .PC_WIDTH (10),
        .RESET_PC (0),
        .PC_LAST  (40)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch       (branch),
        .zero         (zero),
`ifdef PC_FETCH_JUMP_EN
        .jump         (jump),
`endif
        .imm          (imm),
        .pc           (pc),
        .fetch_valid  (fetch_valid),
        .halted       (halted),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int exp_pc, input bit exp_fv,
                             input bit exp_h, input bit exp_e);
        check({tag, ".pc"}, 32'(pc), 32'(exp_pc));
        check({tag, ".fv"}, 32'(fetch_valid), 32'(exp_fv));
        check({tag, ".halted"}, 32'(halted), 32'(exp_h));
        check({tag, ".err"}, 32'(misalign_err), 32'(exp_e));
    endtask

    // Two reset edges, release, then one edge to enter RUN at pc=0
    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        rst    = 1'b1;
        stall  = 1'b0;
        branch = 1'b0;
        zero   = 1'b0;
        imm    = '0;
`ifdef PC_FETCH_JUMP_EN
        jump   = 1'b0;
`endif

        // Reset held two cycles, then release
        step();
        check_all("rst1", 0, 1'b0, 1'b0, 1'b0);
        step();
        check_all("rst2", 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        check_all("idle", 0, 1'b0, 1'b0, 1'b0);
        step();
        check_all("run0", 0, 1'b1, 1'b0, 1'b0);

        // Straight-line run up to PC_LAST, then halt
        for (int i = 1; i <= 10; i++) begin
            step();
            check("seq.pc", 32'(pc), 32'(4 * i));
            check("seq.fv", 32'(fetch_valid), 32'd1);
        end
        step();
        check_all("halt1", 40, 1'b0, 1'b1, 1'b0);
        step();
        check_all("halt2", 40, 1'b0, 1'b1, 1'b0);

        // Mid-run reset clears halt
        rst = 1'b1;
        step();
        check_all("midrst", 0, 1'b0, 1'b0, 1'b0);

        // Branch taken / not taken at pc=12
        rst = 1'b0;
        step();
        step();
        step();
        step();
        check("at12", 32'(pc), 32'd12);
        branch = 1'b1; zero = 1'b1; imm = 32'hFFFF_FFF8;
        step();
        check_all("btaken", 4, 1'b1, 1'b0, 1'b0);
        branch = 1'b0; zero = 1'b0;
        step();
        step();
        check("back12", 32'(pc), 32'd12);
        branch = 1'b1; zero = 1'b0;
        step();
        check_all("bnottaken", 16, 1'b1, 1'b0, 1'b0);
        branch = 1'b0;
        step();
        check("at20", 32'(pc), 32'd20);

        // Stall three cycles at pc=20; branch ignored while stalled
        stall = 1'b1; branch = 1'b1; zero = 1'b1; imm = 32'hFFFF_FFF8;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("stall", 20, 1'b0, 1'b0, 1'b0);
        end
        stall = 1'b0; branch = 1'b0; zero = 1'b0;
        step();
        check_all("unstall", 20, 1'b1, 1'b0, 1'b0);
        step();
        check_all("post", 24, 1'b1, 1'b0, 1'b0);

        // Stall at PC_LAST defers halt until release
        step(); step(); step(); step();
        check("at40", 32'(pc), 32'd40);
        stall = 1'b1;
        step();
        check_all("stall40", 40, 1'b0, 1'b0, 1'b0);
        stall = 1'b0;
        step();
        check_all("rerun40", 40, 1'b1, 1'b0, 1'b0);

        // Taken branch at PC_LAST beats halt
        branch = 1'b1; zero = 1'b1; imm = 32'hFFFF_FFD8;
        step();
        check_all("loopback", 0, 1'b1, 1'b0, 1'b0);
        branch = 1'b0; zero = 1'b0;

        // Misaligned target at pc=8
        step();
        step();
        check("at8", 32'(pc), 32'd8);
        branch = 1'b1; zero = 1'b1; imm = 32'd6;
        step();
        check_all("misal", 8, 1'b0, 1'b1, 1'b1);
        branch = 1'b0; zero = 1'b0;
        step();
        check_all("misal2", 8, 1'b0, 1'b1, 1'b1);
        rst = 1'b1;
        step();
        check_all("misalrst", 0, 1'b0, 1'b0, 1'b0);

        // Wrap-around: 0 -> 1020 -> 4
        rst = 1'b0;
        step();
        branch = 1'b1; zero = 1'b1; imm = 32'd1020;
        step();
        check_all("to1020", 1020, 1'b1, 1'b0, 1'b0);
        imm = 32'd8;
        step();
        check_all("wrap", 4, 1'b1, 1'b0, 1'b0);
        branch = 1'b0; zero = 1'b0;

`ifdef PC_FETCH_JUMP_EN
        // Jump overrides branch/zero
        do_reset();
        step(); step(); step(); step();
        check("at16", 32'(pc), 32'd16);
        jump = 1'b1; branch = 1'b1; zero = 1'b0; imm = 32'hFFFF_FFFC;
        step();
        check_all("jump", 12, 1'b1, 1'b0, 1'b0);
        jump = 1'b0; branch = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_pc_fetch_unit
